// File: rtl/osc_sup_pkg.sv
// ============================================================================
// osc_sup_pkg : shared state encoding and default constants for osc_supervisor
// Rev 1.0
// ============================================================================
`default_nettype none

package osc_sup_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STARTUP = 3'd1,
    MEASURE = 3'd2,
    CHECK   = 3'd3,
    KICK    = 3'd4,
    RUN     = 3'd5,
    FAULT   = 3'd6
  } state_t;

  localparam int DEF_CNT_W          = 16;
  localparam int DEF_TMR_W          = 16;
  localparam int DEF_GATE_CYCLES    = 1000;
  localparam int DEF_STARTUP_CYCLES = 4096;
  localparam int DEF_KICK_CYCLES    = 16;
  localparam int DEF_MAX_RETRY      = 3;

endpackage

`default_nettype wire

// File: rtl/osc_edge_counter.sv
// ============================================================================
// osc_edge_counter : osc_in synchronizer, rising-edge detect, saturating count
// Rev 1.0
// ============================================================================
`default_nettype none

module osc_edge_counter
  import osc_sup_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic s1, s2, s3;
  logic rise;

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      count <= '0;
    end else begin
      s1 <= osc_in;
      s2 <= s1;
      s3 <= s2;
      if (clr)
        count <= '0;
      else if (en && rise && (count != {CNT_W{1'b1}}))
        count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/osc_supervisor.sv
// ============================================================================
// osc_supervisor : oscillator start-up, frequency check, retry/fault supervisor
// Optional OSC_SUP_MONITOR_EN: keep re-measuring after lock. Rev 1.0
// ============================================================================
`default_nettype none

module osc_supervisor
  import osc_sup_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TMR_W          = DEF_TMR_W,
  parameter int GATE_CYCLES    = DEF_GATE_CYCLES,
  parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
  parameter int KICK_CYCLES    = DEF_KICK_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             osc_in,
  input  logic [CNT_W-1:0] f_min,
  input  logic [CNT_W-1:0] f_max,
  output logic             osc_en,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             locked,
  output logic             fault,
  output logic             busy,
  output logic [1:0]       retry_cnt
);

  localparam logic [TMR_W-1:0] STARTUP_LAST = TMR_W'(STARTUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST    = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] KICK_LAST    = TMR_W'(KICK_CYCLES - 1);
  localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRY - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] count;
  logic             cnt_clr;
  logic             cnt_en;
  logic             pass;

  // Counter is held clear outside MEASURE, so every window starts from zero.
  assign cnt_en  = (state == MEASURE);
  assign cnt_clr = ~cnt_en;
  assign pass    = (count >= f_min) && (count <= f_max);

  osc_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk    (clk),
    .rst    (rst),
    .osc_in (osc_in),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      osc_en     <= 1'b0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      busy       <= 1'b0;
      retry_cnt  <= 2'd0;
    end else begin
      meas_valid <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        timer  <= '0;
        osc_en <= 1'b0;
        locked <= 1'b0;
        fault  <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE, FAULT: begin
            if (start) begin
              state     <= STARTUP;
              timer     <= '0;
              retry_cnt <= 2'd0;
              osc_en    <= 1'b1;
              fault     <= 1'b0;
              busy      <= 1'b1;
            end
          end
          STARTUP: begin
            if (timer == STARTUP_LAST) begin
              state <= MEASURE;
              timer <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          MEASURE: begin
            if (timer == GATE_LAST) begin
              state <= CHECK;
              timer <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          CHECK: begin
            meas_count <= count;
            meas_valid <= 1'b1;
            if (pass) begin
              locked <= 1'b1;
`ifdef OSC_SUP_MONITOR_EN
              // Already-locked windows chain straight into the next one.
              if (locked) begin
                state <= MEASURE;
              end else begin
                state <= RUN;
                busy  <= 1'b0;
              end
`else
              state <= RUN;
              busy  <= 1'b0;
`endif
            end else begin
              locked    <= 1'b0;
              osc_en    <= 1'b0;
              retry_cnt <= retry_cnt + 2'd1;
              if (retry_cnt == RETRY_LAST) begin
                state <= FAULT;
                fault <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= KICK;
              end
            end
          end
          KICK: begin
            if (timer == KICK_LAST) begin
              state  <= STARTUP;
              timer  <= '0;
              osc_en <= 1'b1;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          RUN: begin
`ifdef OSC_SUP_MONITOR_EN
            state <= MEASURE;
            timer <= '0;
            busy  <= 1'b1;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_osc_supervisor.sv
// ============================================================================
// tb_osc_supervisor : directed self-checking bench for osc_supervisor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_osc_supervisor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        osc_in = 1'b0;
  logic [15:0] f_min = 16'd10;
  logic [15:0] f_max = 16'd20;
  logic        osc_en;
  logic [15:0] meas_count;
  logic        meas_valid;
  logic        locked;
  logic        fault;
  logic        busy;
  logic [1:0]  retry_cnt;

  int checks = 0;
  int errors = 0;

  int osc_per    = 0;
  int ph         = 0;
  int bph        = 0;
  int burst_n    = 0;
  int burst_done = 0;

  osc_supervisor #(
    .CNT_W          (16),
    .TMR_W          (16),
    .GATE_CYCLES    (100),
    .STARTUP_CYCLES (50),
    .KICK_CYCLES    (16),
    .MAX_RETRY      (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .osc_in     (osc_in),
    .f_min      (f_min),
    .f_max      (f_max),
    .osc_en     (osc_en),
    .meas_count (meas_count),
    .meas_valid (meas_valid),
    .locked     (locked),
    .fault      (fault),
    .busy       (busy),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  // Oscillator model: free-running square wave of osc_per clk, or a burst
  // of 4-cycle pulses whenever burst_n is raised while osc_per is 0.
  always @(negedge clk) begin
    if (osc_per != 0) begin
      osc_in = (ph < osc_per / 2);
      ph = (ph + 1 >= osc_per) ? 0 : ph + 1;
    end else if (burst_done != burst_n) begin
      osc_in = (bph < 2);
      if (bph == 3) begin
        bph = 0;
        burst_done++;
      end else begin
        bph++;
      end
    end else begin
      osc_in = 1'b0;
      ph = 0;
      bph = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!meas_valid && n < budget);
    chk(tag, {31'd0, meas_valid}, 32'd1);
  endtask

  task automatic count_valid(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (meas_valid) pulses++;
    end
  endtask

  initial begin
    int n;
    int pulses;

    repeat (3) @(negedge clk);
    chk("rst_osc_en", {31'd0, osc_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_valid", {31'd0, meas_valid}, 0);
    chk("rst_count", {16'd0, meas_count}, 0);
    chk("rst_retry", {30'd0, retry_cnt}, 0);
    rst = 1'b0;

    // Period 7: ~14 edges per window, lock
    osc_per = 7;
    @(negedge clk);
    chk("idle_osc_en", {31'd0, osc_en}, 0);
    pulse_start();
    chk("start_osc_en", {31'd0, osc_en}, 1);
    chk("start_busy", {31'd0, busy}, 1);
    wait_valid("p7_valid", 400);
    chk("p7_count_range", {31'd0, (meas_count >= 16'd13 && meas_count <= 16'd15)}, 1);
    chk("p7_locked", {31'd0, locked}, 1);
    chk("p7_fault", {31'd0, fault}, 0);
    chk("p7_busy", {31'd0, busy}, 0);
`ifdef OSC_SUP_MONITOR_EN
    wait_valid("mon_valid2", 400);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!meas_valid && n < 400);
    chk("mon_interval", n, 101);
    chk("mon_locked", {31'd0, locked}, 1);
    osc_per = 0;
    wait_valid("mon_stop_valid", 400);
    chk("mon_drop_locked", {31'd0, locked}, 0);
    chk("mon_kick_osc_en", {31'd0, osc_en}, 0);
    chk("mon_retry", {30'd0, retry_cnt}, 1);
`else
    count_valid(250, pulses);
    chk("run_static", pulses, 0);
    chk("run_locked", {31'd0, locked}, 1);
`endif

    // Stuck-low oscillator: three failures, kicks of 16 cycles, fault
    pulse_abort();
    chk("abort_locked", {31'd0, locked}, 0);
    osc_per = 0;
    pulse_start();
    for (int i = 1; i <= 3; i++) begin
      wait_valid($sformatf("stuck_valid%0d", i), 400);
      chk($sformatf("stuck_count%0d", i), {16'd0, meas_count}, 0);
      chk($sformatf("stuck_retry%0d", i), {30'd0, retry_cnt}, i);
      if (i < 3) begin
        n = 0;
        while (osc_en == 1'b0 && n < 100) begin
          n++;
          @(negedge clk);
        end
        chk($sformatf("kick_len%0d", i), n, 16);
      end
    end
    chk("stuck_fault", {31'd0, fault}, 1);
    chk("stuck_osc_en", {31'd0, osc_en}, 0);
    chk("stuck_busy", {31'd0, busy}, 0);

    // Period 3: ~33 edges exceed f_max, fault again; then period 8 locks
    osc_per = 3;
    pulse_start();
    chk("restart_retry", {30'd0, retry_cnt}, 0);
    chk("restart_fault", {31'd0, fault}, 0);
    for (int i = 1; i <= 3; i++) begin
      wait_valid($sformatf("p3_valid%0d", i), 400);
      chk($sformatf("p3_range%0d", i), {31'd0, (meas_count >= 16'd33 && meas_count <= 16'd34)}, 1);
      chk($sformatf("p3_retry%0d", i), {30'd0, retry_cnt}, i);
    end
    chk("p3_fault", {31'd0, fault}, 1);
    osc_per = 8;
    pulse_start();
    chk("p8_retry0", {30'd0, retry_cnt}, 0);
    chk("p8_fault0", {31'd0, fault}, 0);
    wait_valid("p8_valid", 400);
    chk("p8_range", {31'd0, (meas_count >= 16'd12 && meas_count <= 16'd13)}, 1);
    chk("p8_locked", {31'd0, locked}, 1);

    // Exactly 12 edges with f_min == f_max == 12
    pulse_abort();
    osc_per = 0;
    f_min = 16'd12;
    f_max = 16'd12;
    pulse_start();
    repeat (70) @(negedge clk);
    burst_n = burst_n + 12;
    wait_valid("eq_valid", 400);
    chk("eq_count", {16'd0, meas_count}, 12);
    chk("eq_locked", {31'd0, locked}, 1);

    // abort together with start mid-MEASURE: back to idle, no valid, count kept
    pulse_abort();
    osc_per = 7;
    f_min = 16'd10;
    f_max = 16'd20;
    pulse_start();
    repeat (80) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_meas_osc_en", {31'd0, osc_en}, 0);
    chk("abort_meas_busy", {31'd0, busy}, 0);
    count_valid(200, pulses);
    chk("abort_no_valid", pulses, 0);
    chk("abort_keep_count", {16'd0, meas_count}, 12);
    chk("abort_idle_osc_en", {31'd0, osc_en}, 0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_start_idle", {31'd0, osc_en}, 0);

    // Inverted limits always fail; retry_cnt survives abort
    f_min = 16'd25;
    f_max = 16'd5;
    pulse_start();
    wait_valid("inv_valid", 400);
    chk("inv_locked", {31'd0, locked}, 0);
    chk("inv_retry", {30'd0, retry_cnt}, 1);
    pulse_abort();
    chk("abort_keep_retry", {30'd0, retry_cnt}, 1);

    // Asynchronous reset mid-operation
    f_min = 16'd10;
    f_max = 16'd20;
    pulse_start();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_osc_en", {31'd0, osc_en}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_retry", {30'd0, retry_cnt}, 0);
    chk("async_rst_count", {16'd0, meas_count}, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/osc_supervisor.md
Name: osc_supervisor

Overview:
- Digital start-up and frequency supervisor for the on-chip analog oscillator.
- Drives the oscillator enable and waits a fixed start-up time.
- Counts rising edges of the comparator-squared oscillator output over a fixed gate window of clk cycles.
- Declares lock, or retries with an enable kick, and raises fault after repeated failures. Status goes to the dedicated digital outputs.

Parameters:
- CNT_W, 16, width of the edge counter and frequency limits.
- TMR_W, 16, width of the cycle timer.
- GATE_CYCLES, 1000, measurement window in clk cycles; must fit in TMR_W.
- STARTUP_CYCLES, 4096, settle time after enable in clk cycles; must fit in TMR_W.
- KICK_CYCLES, 16, enable-low time before each retry.
- MAX_RETRY, 3, number of failed checks tolerated before fault; range 1..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle request to start the oscillator.
- abort  in  1  return to idle; has priority over all other inputs.
- osc_in  in  1  asynchronous squared oscillator output.
- f_min  in  CNT_W  lowest acceptable edge count.
- f_max  in  CNT_W  highest acceptable edge count.
- osc_en  out  1  oscillator enable.
- meas_count  out  CNT_W  last completed edge count.
- meas_valid  out  1  one-cycle pulse when meas_count updates.
- locked  out  1  frequency is within limits.
- fault  out  1  retries exhausted.
- busy  out  1  state is not IDLE, RUN or FAULT.
- retry_cnt  out  2  failed checks since the last start.

Behaviour:
- Reset: every output is 0; state is IDLE; timer, edge counter and retry_cnt are 0.
- Input path: osc_in passes through a 2-flop synchronizer plus a third flop. An edge is s2 & ~s3, so edge latency is 3 clk cycles.
- Edge counter: saturates at all-ones with no wrap. It is cleared on entry to MEASURE.
- IDLE: osc_en=0. On start (and no abort), go to STARTUP with retry_cnt=0 and timer=0.
- STARTUP: osc_en=1. The timer increments each cycle; at timer==STARTUP_CYCLES-1 go to MEASURE, clearing timer and edge counter.
- MEASURE: osc_en=1. Edges are counted for exactly GATE_CYCLES cycles, including an edge in the final cycle. Then go to CHECK.
- CHECK (1 cycle):
  - Registers meas_count and pulses meas_valid on the following cycle.
  - Pass condition is f_min<=count<=f_max, unsigned and inclusive. On pass: go to RUN; locked=1 from the next cycle.
  - On fail with retry_cnt==MAX_RETRY-1: go to FAULT and increment retry_cnt.
  - On any other fail: increment retry_cnt and go to KICK.
  - If f_min>f_max, every check fails.
- KICK: osc_en=0 for KICK_CYCLES cycles, then STARTUP.
- RUN: osc_en=1, locked=1. Stays until abort.
- FAULT: osc_en=0, fault=1. On start, go to STARTUP with retry_cnt=0 and fault cleared. Otherwise hold.
- abort:
  - From any state, abort goes to IDLE on the next edge and clears osc_en, locked, fault, busy and the timer.
  - meas_count and retry_cnt hold their values.
  - If abort and start arrive in the same cycle, abort wins.
- start outside IDLE and FAULT is ignored.
- rst asserted mid-operation returns all outputs to their reset values immediately (asynchronous).

Optional Feature:
- Macro: OSC_SUP_MONITOR_EN.
- Defined:
  - RUN re-enters MEASURE back-to-back, with locked held at 1 during monitoring windows.
  - Each completed window pulses meas_valid.
  - A failing monitor check clears locked and follows the normal fail path: retry_cnt increment, then KICK or FAULT.
  - retry_cnt is not reset by passing monitor checks.
- Not defined: RUN is static and no further measurements occur after lock.

Decomposition:
- Package osc_sup_pkg holds:
  - the state enum: IDLE, STARTUP, MEASURE, CHECK, KICK, RUN, FAULT;
  - the default width and cycle constants.
- One sub-module, osc_edge_counter: synchronizer, edge detect, and saturating counter with clear and enable.
- The FSM and timer live in osc_supervisor.

Test Plan:
Common bench settings: GATE=100, STARTUP=50, KICK=16, MAX_RETRY=3, f_min=10, f_max=20.
- Osc period 7 clk, pulse start:
  - osc_en rises the cycle after start.
  - meas_valid fires with meas_count=14±1.
  - locked=1 and fault=0.
- osc_in stuck 0:
  - Three checks occur, each giving meas_count=0.
  - retry_cnt steps 1,2,3, with osc_en low for 16 cycles between attempts.
  - fault=1 and osc_en=0 at the end.
- Period 3 clk (about 33 edges): the check fails on f_max. A second start from FAULT restarts with retry_cnt=0. Moving the frequency to period 8 gives lock.
- abort asserted mid-MEASURE and simultaneously with start:
  - IDLE next cycle, osc_en=0.
  - No meas_valid pulse.
  - Previous meas_count retained.
- f_min=f_max=12 with exactly 12 edges gives lock; f_min=25, f_max=5 always fails.
- With OSC_SUP_MONITOR_EN defined:
  - After lock, meas_valid pulses every GATE_CYCLES+1 cycles.
  - Stopping osc_in drops locked after the next window and enters KICK.
